// File: rtl/led7_scan_disp.sv
// led7_scan_disp
//  Display end of the counter -> 7-segment path. A 5-bit binary value is
//  captured on load, split into two BCD digits and shown on a 2-digit
//  common-anode display that is time-multiplexed one digit at a time.
//
//  Pipeline: edge k captures val_in into hold; edge k+1 derives the
//  tens/units/err registers from hold; edge k+2 drives seg from them.
//
// Ports
//  ck      in   1  clock, rising edge
//  rs      in   1  synchronous active-low reset
//  val_in  in   5  binary value to display
//  load    in   1  capture strobe for val_in
//  seg     out  7  {g,f,e,d,c,b,a}, active-low, registered
//  dig_en  out  2  [1]=tens, [0]=units, active-low, registered
//  err     out  1  held value exceeds MAX_VAL, registered
module led7_scan_disp #(
  parameter int SCAN_DIV = 50000,
  parameter int MAX_VAL  = 24,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       ck,
  input  logic       rs,
  input  logic [4:0] val_in,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       err
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segment pattern for one decimal digit; anything else is dark.
  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [4:0]    hold_r;
  logic [3:0]    tens_r;
  logic [3:0]    units_r;
  logic          err_r;
  logic [PW-1:0] presc_r;
  logic          sel_r;
  logic [6:0]    seg_r;
  logic [1:0]    dig_en_r;

  logic [3:0]    tens_s;
  logic [4:0]    units_full_s;
  logic          over_s;
  logic [PW-1:0] presc_nxt_s;
  logic          sel_nxt_s;
  logic [6:0]    tens_seg_s;
  logic [6:0]    units_seg_s;
  logic [6:0]    seg_nxt_s;

  // Binary to BCD by comparison ladder; hold never exceeds 31.
  always_comb begin
    tens_s = 4'd0;
    if (hold_r >= 5'd30) begin
      tens_s = 4'd3;
    end else if (hold_r >= 5'd20) begin
      tens_s = 4'd2;
    end else if (hold_r >= 5'd10) begin
      tens_s = 4'd1;
    end else begin
      tens_s = 4'd0;
    end
    units_full_s = hold_r - ({1'b0, tens_s} * 5'd10);
    over_s       = (int'(hold_r) > MAX_VAL);
  end

  // Scan prescaler and digit select for the coming edge.
  always_comb begin
    presc_nxt_s = presc_r;
    sel_nxt_s   = sel_r;
    if (presc_r == PRESC_LAST) begin
      presc_nxt_s = '0;
      sel_nxt_s   = ~sel_r;
    end else begin
      presc_nxt_s = presc_r + 1'b1;
      sel_nxt_s   = sel_r;
    end
  end

  // Segment content for the digit that will be enabled after this edge,
  // so seg and dig_en always switch together.
  always_comb begin
    tens_seg_s  = SEG_BLANK;
    units_seg_s = SEG_BLANK;
    if (err_r) begin
      tens_seg_s  = SEG_DASH;
      units_seg_s = SEG_DASH;
    end else if (BLANK_LZ && (tens_r == 4'd0)) begin
      tens_seg_s  = SEG_BLANK;
      units_seg_s = seg_of_digit(units_r);
    end else begin
      tens_seg_s  = seg_of_digit(tens_r);
      units_seg_s = seg_of_digit(units_r);
    end
    seg_nxt_s = sel_nxt_s ? tens_seg_s : units_seg_s;
  end

  // All state: capture, BCD stage, scan counter and registered outputs.
  always_ff @(posedge ck) begin
    if (!rs) begin
      hold_r   <= 5'd0;
      tens_r   <= 4'd0;
      units_r  <= 4'd0;
      err_r    <= 1'b0;
      presc_r  <= '0;
      sel_r    <= 1'b0;
      seg_r    <= SEG_BLANK;
      dig_en_r <= 2'b11;
    end else begin
      if (load) begin
        hold_r <= val_in;
      end else begin
        hold_r <= hold_r;
      end
      tens_r   <= tens_s;
      units_r  <= units_full_s[3:0];
      err_r    <= over_s;
      presc_r  <= presc_nxt_s;
      sel_r    <= sel_nxt_s;
      seg_r    <= seg_nxt_s;
      dig_en_r <= sel_nxt_s ? 2'b01 : 2'b10;
    end
  end

  assign seg    = seg_r;
  assign dig_en = dig_en_r;
  assign err    = err_r;

endmodule

// File: tb/tb_led7_scan_disp.sv
// tb_led7_scan_disp
//  Directed and random stimulus for led7_scan_disp (SCAN_DIV=4), with one
//  instance blanking the leading zero and one showing it. Expected outputs
//  come from a value-level model: decimal split by division, scan slot from
//  the edge count since reset, and a two-edge display latency.
module tb_led7_scan_disp;

  localparam int SD = 4;
  localparam int MV = 24;
  localparam logic [6:0] SEGTAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       ck = 1'b0;
  logic       rs;
  logic       load;
  logic [4:0] val_in;
  logic [6:0] seg1, seg0;
  logic [1:0] dig1, dig0;
  logic       err1, err0;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: value captured, value currently on the display stage,
  // edges since reset released.
  int m_hold = 0;
  int m_show = 0;
  int n      = 0;

  always #5 ck = ~ck;

  led7_scan_disp #(.SCAN_DIV(SD), .MAX_VAL(MV), .BLANK_LZ(1'b1)) dut (
    .ck(ck), .rs(rs), .val_in(val_in), .load(load),
    .seg(seg1), .dig_en(dig1), .err(err1)
  );

  led7_scan_disp #(.SCAN_DIV(SD), .MAX_VAL(MV), .BLANK_LZ(1'b0)) dut0 (
    .ck(ck), .rs(rs), .val_in(val_in), .load(load),
    .seg(seg0), .dig_en(dig0), .err(err0)
  );

  function automatic logic [6:0] exp_seg(input int v, input bit tens_slot, input bit blank);
    int t;
    int u;
    if (v > MV) return 7'b0111111;
    t = v / 10;
    u = v % 10;
    if (tens_slot) begin
      if (blank && t == 0) return 7'b1111111;
      return SEGTAB[t];
    end
    return SEGTAB[u];
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, got, exp, n);
    end
  endtask

  // One clock edge with the given inputs, then compare both instances.
  task automatic cyc(input bit r, input bit ld, input int v);
    logic [6:0] es1, es0;
    logic [1:0] ed;
    logic       ee;
    bit         sel;
    rs     = r;
    load   = ld;
    val_in = v[4:0];
    @(posedge ck);
    if (!r) begin
      m_hold = 0;
      m_show = 0;
      n      = 0;
      es1 = 7'b1111111;
      es0 = 7'b1111111;
      ed  = 2'b11;
      ee  = 1'b0;
    end else begin
      n++;
      sel = ((n / SD) % 2) == 1;
      ed  = sel ? 2'b01 : 2'b10;
      es1 = exp_seg(m_show, sel, 1'b1);
      es0 = exp_seg(m_show, sel, 1'b0);
      ee  = (m_hold > MV);
      m_show = m_hold;
      if (ld) m_hold = v;
    end
    #1;
    check("seg_blank", seg1, es1);
    check("seg_zero", seg0, es0);
    check("dig_en", {5'd0, dig1}, {5'd0, ed});
    check("dig_en_b0", {5'd0, dig0}, {5'd0, ed});
    check("err", {6'd0, err1}, {6'd0, ee});
    check("err_b0", {6'd0, err0}, {6'd0, ee});
  endtask

  initial begin
    rs = 1'b0; load = 1'b0; val_in = 5'd0;

    // Reset for three edges, then free-run across several scan slots.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 0);

    // In-range two-digit value, then single digit, then leading zeros.
    cyc(1'b1, 1'b1, 24);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 5);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 0);

    // Over-range at MAX_VAL+1 and at 31, then back to zero.
    cyc(1'b1, 1'b1, 25);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 31);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 0);

    // Down-counter sweep 24..0 and wrap, with a reset pulse mid-way.
    for (int v = 24; v >= 0; v--) begin
      cyc(1'b1, 1'b1, v);
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 0);
      if (v == 13) begin
        cyc(1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
      end
    end
    cyc(1'b1, 1'b1, 24);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 0);

    // Load held high across a scan toggle.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 9 + i);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 0);

    // Random loads, values across the full 0..31 range, occasional reset.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
